// File: rtl/csr_to_ram_bridge_mb.sv
// CSR external-memory port to NUM_BANKS single-port RAMs; read 2+L, plain write 2, RMW write 3+L.
// One transaction at a time: requests arriving while busy (including the ack cycle) are dropped and flagged.
module csr_to_ram_bridge_mb #(
  parameter int WORD_BIT_WIDTH = 32,
  parameter int BANK_DEPTH     = 8,
  parameter int NUM_BANKS      = 2,
  parameter int RAM_RD_LATENCY = 1,
  localparam int BPW    = WORD_BIT_WIDTH / 8,
  localparam int OFF    = $clog2(BPW),
  localparam int WA     = $clog2(BANK_DEPTH),
  localparam int BA     = $clog2(NUM_BANKS),
  localparam int ADDR_W = OFF + WA + BA
) (
  input  logic                                i_clk,
  input  logic                                i_sync_rst,
  input  logic                                i_req,
  input  logic [ADDR_W-1:0]                   i_byte_addr,
  input  logic                                i_req_is_wr,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_bit_en,
  output logic                                o_rd_ack,
  output logic [WORD_BIT_WIDTH-1:0]           o_rd_data,
  output logic                                o_wr_ack,
  output logic                                o_busy,
  output logic                                o_req_drop,
  output logic [NUM_BANKS-1:0]                o_ram_we,
  output logic [WA-1:0]                       o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data,
  output logic [BPW-1:0]                      o_ram_wr_byte_en,
  input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);
  localparam int W    = WORD_BIT_WIDTH;
  localparam int BA_W = (BA > 0) ? BA : 1;
  localparam logic [1:0] LAT_CNT = 2'(RAM_RD_LATENCY);

  if (W < 8 || (W & (W - 1)) != 0) begin : g_bad_width
    $error("WORD_BIT_WIDTH must be a power of 2 and at least 8");
  end
  if (BANK_DEPTH < 2 || (BANK_DEPTH & (BANK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BANK_DEPTH must be a power of 2 and at least 2");
  end
  if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of 2");
  end
  if (RAM_RD_LATENCY < 1 || RAM_RD_LATENCY > 2) begin : g_bad_lat
    $error("RAM_RD_LATENCY must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_WR, S_RMW_RD, S_RMW_WR, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [BA_W-1:0]     bank_q, bank_d, bank_in;
  logic [W-1:0]        bit_en_q, bit_en_d, wdata_q, wdata_d;
  logic                rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, drop_q, drop_d;
  logic [W-1:0]        rd_data_q, rd_data_d, ram_wd_q, ram_wd_d;
  logic [NUM_BANKS-1:0] ram_we_q, ram_we_d;
  logic [WA-1:0]       ram_addr_q, ram_addr_d, word_in;
  logic [BPW-1:0]      ram_be_q, ram_be_d, full_be_in, partial_in;
  logic [W-1:0]        rd_bank [NUM_BANKS];
  logic [W-1:0]        rd_sel, merged;

  if (BA > 0) begin : g_bank
    assign bank_in = i_byte_addr[ADDR_W-1 -: BA];
  end else begin : g_one_bank
    assign bank_in = '0;
  end
  if (OFF > 0) begin : g_off
    logic unused_byte_off;
    assign unused_byte_off = ^i_byte_addr[OFF-1:0];
  end
  assign word_in = i_byte_addr[OFF +: WA];

  for (genvar i = 0; i < BPW; i++) begin : g_byte
    assign full_be_in[i] = &i_wr_bit_en[8*i +: 8];
    assign partial_in[i] = (|i_wr_bit_en[8*i +: 8]) && !full_be_in[i];
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_rd
    assign rd_bank[b] = i_ram_rd_data[b*W +: W];
  end
  assign rd_sel = rd_bank[bank_q];
  assign merged = (rd_sel & ~bit_en_q) | (wdata_q & bit_en_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    bit_en_d   = bit_en_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    ram_addr_d = ram_addr_q;
    ram_wd_d   = ram_wd_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    ram_we_d   = '0;
    ram_be_d   = '0;
    drop_d     = i_req && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (i_req) begin
          bank_d     = bank_in;
          bit_en_d   = i_wr_bit_en;
          wdata_d    = i_wr_data;
          ram_addr_d = word_in;
          cnt_d      = '0;
          if (!i_req_is_wr) begin
            state_d = S_RD_WAIT;
          end else if (!(|partial_in)) begin
            // Byte-aligned write goes out immediately; an all-zero enable skips the RAM.
            state_d  = S_WR;
            ram_wd_d = i_wr_data;
            ram_be_d = full_be_in;
            if (|full_be_in) ram_we_d = NUM_BANKS'(1) << bank_in;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD_WAIT, S_RMW_RD: begin
        if (cnt_q == LAT_CNT) begin
          if (state_q == S_RD_WAIT) begin
            rd_data_d = rd_sel;
            rd_ack_d  = 1'b1;
            state_d   = S_ACK;
          end else begin
            ram_wd_d = merged;
            ram_be_d = '1;
            ram_we_d = NUM_BANKS'(1) << bank_q;
            state_d  = S_RMW_WR;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR, S_RMW_WR: begin
        wr_ack_d = 1'b1;
        state_d  = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      bit_en_q   <= '0;
      wdata_q    <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      drop_q     <= 1'b0;
      rd_data_q  <= '0;
      ram_we_q   <= '0;
      ram_addr_q <= '0;
      ram_wd_q   <= '0;
      ram_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      bit_en_q   <= bit_en_d;
      wdata_q    <= wdata_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wd_q   <= ram_wd_d;
      ram_be_q   <= ram_be_d;
    end
  end

  assign o_rd_ack         = rd_ack_q;
  assign o_rd_data        = rd_data_q;
  assign o_wr_ack         = wr_ack_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_req_drop       = drop_q;
  assign o_ram_we         = ram_we_q;
  assign o_ram_word_addr  = ram_addr_q;
  assign o_ram_wr_data    = ram_wd_q;
  assign o_ram_wr_byte_en = ram_be_q;
endmodule

// File: tb/tb_csr_to_ram_bridge_mb.sv
// Bench: two bridges (read latency 1 and 2) share the same CSR stimulus, each with its own RAM model.
module tb_csr_to_ram_bridge_mb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        is_wr = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] bit_en = '0;

  logic        rd_ack  [2];
  logic        wr_ack  [2];
  logic        busy    [2];
  logic        drop    [2];
  logic [31:0] rd_data [2];
  logic [1:0]  ram_we  [2];
  logic [2:0]  waddr   [2];
  logic [31:0] ram_wd  [2];
  logic [3:0]  ram_be  [2];
  logic [63:0] ram_rd  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [2][8];
    logic [63:0] rd_p1, rd_p2;

    csr_to_ram_bridge_mb #(.RAM_RD_LATENCY(g + 1)) u_dut (
      .i_clk(clk), .i_sync_rst(rst), .i_req(req), .i_byte_addr(addr),
      .i_req_is_wr(is_wr), .i_wr_data(wdata), .i_wr_bit_en(bit_en),
      .o_rd_ack(rd_ack[g]), .o_rd_data(rd_data[g]), .o_wr_ack(wr_ack[g]),
      .o_busy(busy[g]), .o_req_drop(drop[g]), .o_ram_we(ram_we[g]),
      .o_ram_word_addr(waddr[g]), .o_ram_wr_data(ram_wd[g]),
      .o_ram_wr_byte_en(ram_be[g]), .i_ram_rd_data(ram_rd[g])
    );

    always @(posedge clk) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++)
          if (ram_we[g][b] && ram_be[g][i]) mem[b][waddr[g]][8*i +: 8] <= ram_wd[g][8*i +: 8];
      rd_p1 <= {mem[1][waddr[g]], mem[0][waddr[g]]};
      rd_p2 <= rd_p1;
    end
    assign ram_rd[g] = (g == 0) ? rd_p1 : rd_p2;
  end

  typedef struct {
    int          dut;
    int          cyc;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  // coll: cycle in which a stray write request is driven (0 = none);
  // rstc: cycle in which reset is pulsed (0 = none, transaction then never completes).
  task automatic txn(input bit w, input logic [5:0] a, input logic [31:0] d,
                     input logic [31:0] be, input int coll, input int rstc);
    int          bk, wi;
    logic [3:0]  fb;
    bit          part, rmw;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    int          exp_we_cyc [2];
    int          wcnt [2];
    int          acnt [2];
    int          dcnt [2];
    exp_t        e;
    bk = int'(a[5]);
    wi = int'(a[4:2]);
    part = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fb[i] = &be[8*i +: 8];
      if (be[8*i +: 8] != 8'h00 && be[8*i +: 8] != 8'hFF) part = 1'b1;
    end
    rmw    = w && part;
    exp_wd = (model[bk][wi] & ~be) | (d & be);
    exp_be = rmw ? 4'hF : fb;
    for (int k = 0; k < 2; k++) begin
      wcnt[k] = 0; acnt[k] = 0; dcnt[k] = 0;
      exp_we_cyc[k] = (!w || (!rmw && be == 0)) ? -1 : (rmw ? 3 + k : 1);
      if (rstc == 0) begin
        e.dut  = k;
        e.cyc  = !w ? 3 + k : (rmw ? 4 + k : 2);
        e.wr   = w;
        e.data = model[bk][wi];
        sb.push_back(e);
      end
    end
    if (w && rstc == 0) model[bk][wi] = exp_wd;

    @(posedge clk); #1;
    req = 1'b1; is_wr = w; addr = a; wdata = d; bit_en = be;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ram_we[k] !== 2'b00) begin
          wcnt[k]++;
          chk("we_cycle", 64'(c), 64'(exp_we_cyc[k]));
          chk("we_bank", 64'(ram_we[k]), 64'(2'b01 << bk));
          chk("we_byte_en", 64'(ram_be[k]), 64'(exp_be));
          chk("we_data", 64'(ram_wd[k] & bmask(exp_be)), 64'(exp_wd & bmask(exp_be)));
        end else begin
          chk("byte_en_idle", 64'(ram_be[k]), 64'h0);
        end
        if (rd_ack[k] === 1'b1 || wr_ack[k] === 1'b1) begin
          acnt[k]++;
          chk("ack_expected", 64'(sb.size() > 0), 64'h1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_dut", 64'(k), 64'(e.dut));
            chk("ack_cycle", 64'(c), 64'(e.cyc));
            chk("ack_kind", {62'h0, rd_ack[k], wr_ack[k]}, {62'h0, !e.wr, e.wr});
            if (!e.wr) chk("rd_data", 64'(rd_data[k]), 64'(e.data));
          end
        end
        if (drop[k] === 1'b1) begin
          dcnt[k]++;
          chk("drop_cycle", 64'(c), 64'(coll + 1));
        end
        if (rstc > 0 && c == rstc + 1) chk("busy_after_rst", 64'(busy[k]), 64'h0);
      end
      if (c == coll) begin
        req = 1'b1; is_wr = 1'b1; addr = 6'h00; wdata = 32'h0BAD0BAD; bit_en = '1;
      end else begin
        req = 1'b0;
      end
      rst = (c == rstc);
    end
    for (int k = 0; k < 2; k++) begin
      chk("we_count", 64'(wcnt[k]), 64'((exp_we_cyc[k] >= 0 && rstc == 0) ? 1 : 0));
      chk("ack_count", 64'(acnt[k]), 64'((rstc == 0) ? 1 : 0));
      chk("drop_count", 64'(dcnt[k]), 64'((coll > 0) ? 1 : 0));
      chk("idle_at_end", 64'(busy[k]), 64'h0);
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    sb.delete();
  endtask

  initial begin
    // Reset held three cycles; every output must read zero.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_ack", 64'(rd_ack[k]), 64'h0);
      chk("rst_rd_data", 64'(rd_data[k]), 64'h0);
      chk("rst_wr_ack", 64'(wr_ack[k]), 64'h0);
      chk("rst_busy", 64'(busy[k]), 64'h0);
      chk("rst_drop", 64'(drop[k]), 64'h0);
      chk("rst_ram_we", 64'(ram_we[k]), 64'h0);
      chk("rst_word_addr", 64'(waddr[k]), 64'h0);
      chk("rst_wr_data", 64'(ram_wd[k]), 64'h0);
      chk("rst_byte_en", 64'(ram_be[k]), 64'h0);
    end
    rst = 1'b0;

    // Plain write and read-back, bank 1 word 1.
    txn(1'b1, 6'h24, 32'hDEADBEEF, 32'hFFFF_FFFF, 0, 0);
    txn(1'b0, 6'h24, 32'h0, 32'h0, 0, 0);
    // Byte-aligned partial write, no RMW.
    txn(1'b1, 6'h24, 32'h0000_1200, 32'h0000_FF00, 0, 0);
    txn(1'b0, 6'h24, 32'h0, 32'h0, 0, 0);
    // Sub-byte write needs RMW.
    txn(1'b1, 6'h24, 32'hDEADBEEF, 32'hFFFF_FFFF, 0, 0);
    txn(1'b1, 6'h24, 32'h0000_0005, 32'h0000_000F, 0, 0);
    txn(1'b0, 6'h24, 32'h0, 32'h0, 0, 0);
    // Collision while busy, and collision on the ack cycle, in bank 0.
    txn(1'b0, 6'h24, 32'h0, 32'h0, 1, 0);
    txn(1'b1, 6'h08, 32'h1122_3344, 32'hFFFF_FFFF, 2, 0);
    txn(1'b1, 6'h09, 32'h00AB_0070, 32'h00FF_0F00, 0, 0);
    txn(1'b0, 6'h0A, 32'h0, 32'h0, 0, 0);
    // All-zero bit enable: ack without any RAM write.
    txn(1'b1, 6'h24, 32'hFFFF_FFFF, 32'h0, 0, 0);
    txn(1'b0, 6'h24, 32'h0, 32'h0, 0, 0);
    // Reset during the RMW read phase aborts cleanly; a read then still works.
    txn(1'b1, 6'h24, 32'h0000_00A0, 32'h0000_00F0, 0, 1);
    txn(1'b0, 6'h24, 32'h0, 32'h0, 0, 0);
    txn(1'b0, 6'h08, 32'h0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
